// File: rtl/nfc_pkg.sv
// Shared SFR offsets, flash opcodes and encodings for the NAND register-write sequencer.
package nfc_pkg;

   localparam logic [8:0] SfrCmd    = 9'h010;
   localparam logic [8:0] SfrCtl    = 9'h011;
   localparam logic [8:0] SfrCfg    = 9'h012;
   localparam logic [8:0] SfrAddrCnt = 9'h01F;
   localparam logic [8:0] SfrCol    = 9'h020;
   localparam logic [8:0] SfrRow    = 9'h024;

   localparam logic [7:0] OpcRead1  = 8'h00;
   localparam logic [7:0] OpcRead2  = 8'h30;
   localparam logic [7:0] OpcProg1  = 8'h80;
   localparam logic [7:0] OpcProg2  = 8'h10;
   localparam logic [7:0] OpcErase1 = 8'h60;
   localparam logic [7:0] OpcErase2 = 8'hD0;

   localparam logic [7:0] CtlAddrEn   = 8'h02;
   localparam logic [7:0] CtlReadXfer = 8'h01;
   localparam logic [7:0] CtlProgXfer = 8'h09;

   typedef enum logic [1:0] {
      OpRead  = 2'b00,
      OpProg  = 2'b01,
      OpErase = 2'b10,
      OpRsvd  = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      StIdle, StCfg, StAcnt, StCmd1, StCol, StRow, StAen, StData, StWdat, StCmd2, StWrb, StFin
   } state_e;

   function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt);
      return (cnt > 3'd4) ? 3'd4 : cnt;
   endfunction

   function automatic logic [7:0] cmd1_opc(input op_e op);
      case (op)
         OpProg:  return OpcProg1;
         OpErase: return OpcErase1;
         default: return OpcRead1;
      endcase
   endfunction

   function automatic logic [7:0] cmd2_opc(input op_e op);
      case (op)
         OpProg:  return OpcProg2;
         OpErase: return OpcErase2;
         default: return OpcRead2;
      endcase
   endfunction

endpackage

// File: rtl/nfc_reg_seq_if.sv
// Request/completion handshake and SFR write bus of the register-write sequencer.
interface nfc_reg_seq_if;
   logic        req;
   logic [1:0]  req_op;
   logic [3:0]  req_ceb;
   logic [1:0]  req_mode;
   logic [2:0]  req_col_cnt;
   logic [2:0]  req_row_cnt;
   logic [31:0] req_col;
   logic [31:0] req_row;
   logic        dat_done;
   logic        rnb_i;
   logic        busy;
   logic        done;
   logic        err;
   logic        nfc_reg_wr;
   logic        nfc_reg_rd;
   logic [8:0]  nfc_reg_addr;
   logic [7:0]  nfc_reg_dout;

   modport master (
      output req, req_op, req_ceb, req_mode, req_col_cnt, req_row_cnt, req_col, req_row,
      output dat_done, rnb_i,
      input  busy, done, err, nfc_reg_wr, nfc_reg_rd, nfc_reg_addr, nfc_reg_dout
   );

   modport slave (
      input  req, req_op, req_ceb, req_mode, req_col_cnt, req_row_cnt, req_col, req_row,
      input  dat_done, rnb_i,
      output busy, done, err, nfc_reg_wr, nfc_reg_rd, nfc_reg_addr, nfc_reg_dout
   );
endinterface

// File: rtl/nfc_rb_wait.sv
// Ready/busy wait: synchronizes rnb_i, enforces tWB after the last command, then waits for
// ready or a saturating timeout. Counters are held clear while start is low.
module nfc_rb_wait #(
   parameter int unsigned TMO_W   = 16,
   parameter int unsigned TWB_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic rnb_i,
   output logic ready,
   output logic timeout
);

   localparam int unsigned TwbW = $clog2(TWB_CYC + 1);

   logic [1:0]       sync_q;
   logic [TwbW-1:0]  twb_q;
   logic [TMO_W-1:0] tmo_q;
   logic             twb_done;

   // Idle level of the flash line is ready, so the synchronizer resets high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rnb_i};
      end
   end

   assign twb_done = (twb_q == TwbW'(TWB_CYC));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         twb_q <= '0;
         tmo_q <= '0;
      end else if (!start) begin
         twb_q <= '0;
         tmo_q <= '0;
      end else if (!twb_done) begin
         twb_q <= twb_q + 1'b1;
      end else if (!(&tmo_q)) begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   assign ready   = start & twb_done & sync_q[1];
   assign timeout = start & twb_done & (&tmo_q);

endmodule

// File: rtl/nfc_reg_seq.sv
// NAND register-write sequencer: expands one read/program/erase request into the SFR
// writes that configure the controller, issue command/address and start data transfer.
module nfc_reg_seq #(
   parameter int unsigned TMO_W   = 16,
   parameter int unsigned TWB_CYC = 8
) (
   input  logic         clk,
   input  logic         rst,
   nfc_reg_seq_if.slave bus
);
   import nfc_pkg::*;

   state_e      state_q, state_d;
   op_e         op_q;
   logic [3:0]  ceb_q;
   logic [1:0]  mode_q;
   logic [2:0]  col_cnt_q;
   logic [2:0]  row_cnt_q;
   logic [31:0] col_q;
   logic [31:0] row_q;
   logic [1:0]  idx_q, idx_d;
   logic        err_q, err_d;

   logic        accept;
   logic        rb_start;
   logic        rb_ready;
   logic        rb_timeout;
   logic        wr;
   logic [8:0]  addr;
   logic [7:0]  dout;

   assign accept = (state_q == StIdle) && bus.req;

   nfc_rb_wait #(
      .TMO_W  (TMO_W),
      .TWB_CYC(TWB_CYC)
   ) u_rb_wait (
      .clk    (clk),
      .rst    (rst),
      .start  (rb_start),
      .rnb_i  (bus.rnb_i),
      .ready  (rb_ready),
      .timeout(rb_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Erase carries no column address, so its column count is forced to zero at capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= OpRead;
         ceb_q     <= '0;
         mode_q    <= '0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
      end else if (accept) begin
         op_q      <= op_e'(bus.req_op);
         ceb_q     <= bus.req_ceb;
         mode_q    <= bus.req_mode;
         col_cnt_q <= (op_e'(bus.req_op) == OpErase) ? 3'd0 : clamp_cnt(bus.req_col_cnt);
         row_cnt_q <= clamp_cnt(bus.req_row_cnt);
         col_q     <= bus.req_col;
         row_q     <= bus.req_row;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      err_d    = err_q;
      wr       = 1'b0;
      addr     = '0;
      dout     = '0;
      rb_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               state_d = StCfg;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         StCfg: begin
            if (op_q == OpRsvd) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               wr      = 1'b1;
               addr    = SfrCfg;
               dout    = {2'b00, mode_q, ceb_q};
               state_d = StAcnt;
            end
         end
         StAcnt: begin
            wr      = 1'b1;
            addr    = SfrAddrCnt;
            dout    = {2'b00, col_cnt_q, row_cnt_q};
            state_d = StCmd1;
         end
         StCmd1: begin
            wr      = 1'b1;
            addr    = SfrCmd;
            dout    = cmd1_opc(op_q);
            state_d = (col_cnt_q != 3'd0) ? StCol : (row_cnt_q != 3'd0) ? StRow : StAen;
         end
         StCol: begin
            wr   = 1'b1;
            addr = SfrCol + {7'd0, idx_q};
            dout = col_q[{idx_q, 3'b000} +: 8];
            if ({1'b0, idx_q} == col_cnt_q - 3'd1) begin
               idx_d   = '0;
               state_d = (row_cnt_q != 3'd0) ? StRow : StAen;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         StRow: begin
            wr   = 1'b1;
            addr = SfrRow + {7'd0, idx_q};
            dout = row_q[{idx_q, 3'b000} +: 8];
            if ({1'b0, idx_q} == row_cnt_q - 3'd1) begin
               idx_d   = '0;
               state_d = StAen;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         StAen: begin
            wr      = 1'b1;
            addr    = SfrCtl;
            dout    = CtlAddrEn;
            state_d = (op_q == OpProg) ? StData : StCmd2;
         end
         StData: begin
            wr      = 1'b1;
            addr    = SfrCtl;
            dout    = (op_q == OpProg) ? CtlProgXfer : CtlReadXfer;
            state_d = StWdat;
         end
         StWdat: begin
            if (bus.dat_done) begin
               state_d = (op_q == OpProg) ? StCmd2 : StFin;
            end
         end
         StCmd2: begin
            wr      = 1'b1;
            addr    = SfrCmd;
            dout    = cmd2_opc(op_q);
            state_d = StWrb;
         end
         StWrb: begin
            rb_start = 1'b1;
            // Ready wins over a timeout that saturates in the same cycle.
            if (rb_ready) begin
               state_d = (op_q == OpRead) ? StData : StFin;
            end else if (rb_timeout) begin
               err_d   = 1'b1;
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.busy         = (state_q != StIdle);
   assign bus.done         = (state_q == StFin);
   assign bus.err          = (state_q == StFin) & err_q;
   assign bus.nfc_reg_wr   = wr;
   assign bus.nfc_reg_rd   = 1'b0;
   assign bus.nfc_reg_addr = addr;
   assign bus.nfc_reg_dout = dout;

endmodule

// File: tb/tb_nfc_reg_seq.sv
// Directed bench for nfc_reg_seq: read, erase, program, timeout, reserved op and reset abort.
module tb_nfc_reg_seq;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   bit   rd_seen = 1'b0;
   logic [16:0] wr_q[$];
   logic [16:0] exp_q[$];

   nfc_reg_seq_if bus_if ();

   nfc_reg_seq #(
      .TMO_W  (6),
      .TWB_CYC(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_if.nfc_reg_wr === 1'b1) wr_q.push_back({bus_if.nfc_reg_addr, bus_if.nfc_reg_dout});
      if (bus_if.done === 1'b1) done_cnt++;
      if (bus_if.nfc_reg_rd !== 1'b0) rd_seen = 1'b1;
   end

   function automatic logic [16:0] w(input logic [8:0] a, input logic [7:0] d);
      return {a, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_wr(input logic [16:0] wv, input int bound, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         if (bus_if.nfc_reg_wr === 1'b1 && {bus_if.nfc_reg_addr, bus_if.nfc_reg_dout} === wv)
            ok = 1'b1;
         else
            tick();
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (bus_if.done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, " count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check($sformatf("%s wr%0d", tag, i), {15'd0, wr_q[i]}, {15'd0, exp_q[i]});
   endtask

   task automatic start_req(input logic [1:0] op, input logic [3:0] ceb, input logic [1:0] mode,
                            input logic [2:0] colc, input logic [2:0] rowc,
                            input logic [31:0] col, input logic [31:0] row);
      wr_q.delete();
      exp_q.delete();
      bus_if.req_op      = op;
      bus_if.req_ceb     = ceb;
      bus_if.req_mode    = mode;
      bus_if.req_col_cnt = colc;
      bus_if.req_row_cnt = rowc;
      bus_if.req_col     = col;
      bus_if.req_row     = row;
      bus_if.req         = 1'b1;
      tick();
      bus_if.req         = 1'b0;
   endtask

   initial begin
      int n;
      int n0;
      int d0;
      rst                = 1'b1;
      bus_if.req         = 1'b0;
      bus_if.req_op      = 2'b00;
      bus_if.req_ceb     = 4'hF;
      bus_if.req_mode    = 2'd0;
      bus_if.req_col_cnt = 3'd0;
      bus_if.req_row_cnt = 3'd0;
      bus_if.req_col     = '0;
      bus_if.req_row     = '0;
      bus_if.dat_done    = 1'b0;
      bus_if.rnb_i       = 1'b1;
      tick();
      tick();
      check("reset busy", {31'd0, bus_if.busy}, 32'd0);
      check("reset done", {31'd0, bus_if.done}, 32'd0);
      check("reset err", {31'd0, bus_if.err}, 32'd0);
      check("reset wr", {31'd0, bus_if.nfc_reg_wr}, 32'd0);
      check("reset addr", {23'd0, bus_if.nfc_reg_addr}, 32'd0);
      check("reset dout", {24'd0, bus_if.nfc_reg_dout}, 32'd0);
      rst = 1'b0;
      tick();

      // Page read
      start_req(2'b00, 4'hE, 2'd0, 3'd2, 3'd3, 32'h0000_0400, 32'h0001_2345);
      check("read busy after accept", {31'd0, bus_if.busy}, 32'd1);
      wait_wr(w(9'h010, 8'h30), 30, "read cmd2");
      bus_if.rnb_i = 1'b0;
      repeat (20) tick();
      check("read no data while busy flash", wr_q.size(), 32'd10);
      bus_if.rnb_i = 1'b1;
      wait_wr(w(9'h011, 8'h01), 30, "read data start");
      tick();
      bus_if.dat_done = 1'b1;
      tick();
      bus_if.dat_done = 1'b0;
      wait_done(5, n);
      check("read done", {31'd0, bus_if.done}, 32'd1);
      check("read busy at done", {31'd0, bus_if.busy}, 32'd1);
      check("read err", {31'd0, bus_if.err}, 32'd0);
      exp_q.push_back(w(9'h012, 8'h0E)); exp_q.push_back(w(9'h01F, 8'h13));
      exp_q.push_back(w(9'h010, 8'h00)); exp_q.push_back(w(9'h020, 8'h00));
      exp_q.push_back(w(9'h021, 8'h04)); exp_q.push_back(w(9'h024, 8'h45));
      exp_q.push_back(w(9'h025, 8'h23)); exp_q.push_back(w(9'h026, 8'h01));
      exp_q.push_back(w(9'h011, 8'h02)); exp_q.push_back(w(9'h010, 8'h30));
      exp_q.push_back(w(9'h011, 8'h01));
      check_log("read");
      tick();
      check("read done single", {31'd0, bus_if.done}, 32'd0);
      check("read idle", {31'd0, bus_if.busy}, 32'd0);

      // Block erase with clamped col count, plus a request while busy
      start_req(2'b10, 4'hD, 2'd1, 3'd5, 3'd3, 32'hFFFF_FFFF, 32'h00AB_CDEF);
      bus_if.req_op = 2'b00;
      bus_if.req    = 1'b1;
      tick();
      bus_if.req    = 1'b0;
      wait_wr(w(9'h010, 8'hD0), 30, "erase cmd2");
      bus_if.rnb_i = 1'b0;
      repeat (5) tick();
      bus_if.rnb_i = 1'b1;
      wait_done(40, n);
      check("erase done", {31'd0, bus_if.done}, 32'd1);
      check("erase err", {31'd0, bus_if.err}, 32'd0);
      exp_q.push_back(w(9'h012, 8'h1D)); exp_q.push_back(w(9'h01F, 8'h03));
      exp_q.push_back(w(9'h010, 8'h60)); exp_q.push_back(w(9'h024, 8'hEF));
      exp_q.push_back(w(9'h025, 8'hCD)); exp_q.push_back(w(9'h026, 8'hAB));
      exp_q.push_back(w(9'h011, 8'h02)); exp_q.push_back(w(9'h010, 8'hD0));
      check_log("erase");
      repeat (4) tick();
      check("erase no second run", {31'd0, bus_if.busy}, 32'd0);
      check("erase no extra writes", wr_q.size(), 32'd8);

      // Page program with an early dat_done that must be ignored
      start_req(2'b01, 4'h7, 2'd2, 3'd1, 3'd2, 32'h0000_0055, 32'h0000_1234);
      tick();
      bus_if.dat_done = 1'b1;
      tick();
      bus_if.dat_done = 1'b0;
      wait_wr(w(9'h011, 8'h09), 20, "prog data start");
      repeat (5) tick();
      check("prog waits dat_done", wr_q.size(), 32'd8);
      check("prog busy in wdat", {31'd0, bus_if.busy}, 32'd1);
      bus_if.dat_done = 1'b1;
      tick();
      bus_if.dat_done = 1'b0;
      wait_wr(w(9'h010, 8'h10), 3, "prog cmd2");
      wait_done(30, n);
      check("prog done", {31'd0, bus_if.done}, 32'd1);
      check("prog err", {31'd0, bus_if.err}, 32'd0);
      exp_q.push_back(w(9'h012, 8'h27)); exp_q.push_back(w(9'h01F, 8'h0A));
      exp_q.push_back(w(9'h010, 8'h80)); exp_q.push_back(w(9'h020, 8'h55));
      exp_q.push_back(w(9'h024, 8'h34)); exp_q.push_back(w(9'h025, 8'h12));
      exp_q.push_back(w(9'h011, 8'h02)); exp_q.push_back(w(9'h011, 8'h09));
      exp_q.push_back(w(9'h010, 8'h10));
      check_log("prog");
      tick();

      // Read timeout: CMD2 cycle, then 8 tWB + 64 counting WRB cycles, then FIN
      start_req(2'b00, 4'hE, 2'd0, 3'd0, 3'd1, 32'h0, 32'h0000_0077);
      wait_wr(w(9'h010, 8'h30), 30, "tmo cmd2");
      bus_if.rnb_i = 1'b0;
      wait_done(200, n);
      check("tmo done", {31'd0, bus_if.done}, 32'd1);
      check("tmo latency", n, 32'd73);
      check("tmo err", {31'd0, bus_if.err}, 32'd1);
      exp_q.push_back(w(9'h012, 8'h0E)); exp_q.push_back(w(9'h01F, 8'h01));
      exp_q.push_back(w(9'h010, 8'h00)); exp_q.push_back(w(9'h024, 8'h77));
      exp_q.push_back(w(9'h011, 8'h02)); exp_q.push_back(w(9'h010, 8'h30));
      check_log("tmo");
      bus_if.rnb_i = 1'b1;
      tick();
      check("tmo idle", {31'd0, bus_if.busy}, 32'd0);

      // Reserved op: done+err two cycles after req, no writes
      start_req(2'b11, 4'hE, 2'd0, 3'd2, 3'd2, 32'h0, 32'h0);
      check("rsvd busy", {31'd0, bus_if.busy}, 32'd1);
      check("rsvd not yet done", {31'd0, bus_if.done}, 32'd0);
      tick();
      check("rsvd done", {31'd0, bus_if.done}, 32'd1);
      check("rsvd err", {31'd0, bus_if.err}, 32'd1);
      tick();
      check("rsvd no writes", wr_q.size(), 32'd0);

      // Reset in the middle of the row phase
      start_req(2'b10, 4'hE, 2'd0, 3'd0, 3'd3, 32'h0, 32'h0000_5A42);
      wait_wr(w(9'h024, 8'h42), 20, "rst row0");
      rst = 1'b1;
      #1;
      check("rst busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst wr", {31'd0, bus_if.nfc_reg_wr}, 32'd0);
      check("rst addr", {23'd0, bus_if.nfc_reg_addr}, 32'd0);
      d0 = done_cnt;
      n0 = wr_q.size();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("rst no further writes", wr_q.size(), n0);
      check("rst no done", done_cnt, d0);
      check("rst stays idle", {31'd0, bus_if.busy}, 32'd0);
      check("rd never asserted", {31'd0, rd_seen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
